// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with start/done handshake, held result and a leading-zero display mask.
module bin_to_bcd_seq #(
    parameter int WIDTH_BIN = 16,
    parameter int DIGITS    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH_BIN-1:0] bin,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [4*DIGITS-1:0]  bcd,
    output logic [DIGITS-1:0]    nz_mask
);
    localparam int SW = 4*DIGITS + WIDTH_BIN;
    localparam int CW = $clog2(WIDTH_BIN + 1);

    function automatic int dec_digits_needed();
        logic [WIDTH_BIN+3:0] v;
        int n;
        v = {4'd0, {WIDTH_BIN{1'b1}}};
        n = 0;
        for (int i = 0; i < WIDTH_BIN; i++) begin
            if (v != '0) begin
                v = v / (WIDTH_BIN+4)'(10);
                n++;
            end
        end
        return n;
    endfunction

    localparam int DIGITS_MIN = dec_digits_needed();

    if (WIDTH_BIN < 2 || DIGITS < DIGITS_MIN) begin : g_param_error
        $error("bin_to_bcd_seq: DIGITS too small for WIDTH_BIN, or WIDTH_BIN < 2");
    end

    // Per-nibble +3 correction; nibbles are independent, no carry between them.
    function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] f);
        logic [4*DIGITS-1:0] r;
        logic [3:0]          nib;
        r = f;
        for (int k = 0; k < DIGITS; k++) begin
            nib = f[4*k +: 4];
            if (nib >= 4'd5) begin
                r[4*k +: 4] = nib + 4'd3;
            end else begin
                r[4*k +: 4] = nib;
            end
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] nz_of(input logic [4*DIGITS-1:0] b);
        logic [DIGITS-1:0] m;
        logic              seen;
        m    = '0;
        seen = 1'b0;
        for (int k = DIGITS-1; k >= 0; k--) begin
            seen = seen | (b[4*k +: 4] != 4'd0);
            m[k] = seen;
        end
        m[0] = 1'b1;
        return m;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_r, state_next_s;
    logic [SW-1:0]     sreg_r, sreg_next_s, shifted_s;
    logic [CW-1:0]     cnt_r, cnt_next_s;
    logic              load_result_s;
    logic              ready_r, busy_r, done_r;
    logic [4*DIGITS-1:0] bcd_r;
    logic [DIGITS-1:0] nz_r;

    // Next-state, shift-register and counter logic.
    always_comb begin
        state_next_s  = state_r;
        sreg_next_s   = sreg_r;
        cnt_next_s    = cnt_r;
        load_result_s = 1'b0;
        shifted_s     = {add3(sreg_r[SW-1:WIDTH_BIN]), sreg_r[WIDTH_BIN-1:0]} << 1'b1;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    sreg_next_s  = {{(4*DIGITS){1'b0}}, bin};
                    cnt_next_s   = CW'(WIDTH_BIN);
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sreg_next_s = shifted_s;
                cnt_next_s  = cnt_r - CW'(1);
                // The last shift leaves the finished digits; capture them now so
                // they are already visible while done is high.
                if (cnt_r == CW'(1)) begin
                    state_next_s  = ST_DONE;
                    load_result_s = 1'b1;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            sreg_r  <= '0;
            cnt_r   <= '0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            bcd_r   <= '0;
            nz_r    <= DIGITS'(1'b1);
        end else begin
            state_r <= state_next_s;
            sreg_r  <= sreg_next_s;
            cnt_r   <= cnt_next_s;
            ready_r <= (state_next_s == ST_IDLE);
            busy_r  <= (state_next_s == ST_SHIFT);
            done_r  <= (state_next_s == ST_DONE);
            if (load_result_s) begin
                bcd_r <= shifted_s[SW-1:WIDTH_BIN];
                nz_r  <= nz_of(shifted_s[SW-1:WIDTH_BIN]);
            end else begin
                bcd_r <= bcd_r;
                nz_r  <= nz_r;
            end
        end
    end

    assign ready   = ready_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign bcd     = bcd_r;
    assign nz_mask = nz_r;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: default instance (16 bit, 5 digits) and a small
// instance (6 bit, 2 digits), checked every cycle against a decimal-arithmetic model.
module tb_bin_to_bcd_seq;
    localparam int W0 = 16, D0 = 5, W1 = 6, D1 = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [15:0] bin0 = 16'd0;
    logic [5:0]  bin1 = 6'd0;
    logic        ready0, busy0, done0, ready1, busy1, done1;
    logic [19:0] bcd0;
    logic [4:0]  nz0;
    logic [7:0]  bcd1;
    logic [1:0]  nz1;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    bin_to_bcd_seq #(.WIDTH_BIN(W0), .DIGITS(D0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .bin(bin0),
        .ready(ready0), .busy(busy0), .done(done0), .bcd(bcd0), .nz_mask(nz0));

    bin_to_bcd_seq #(.WIDTH_BIN(W1), .DIGITS(D1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .bin(bin1),
        .ready(ready1), .busy(busy1), .done(done1), .bcd(bcd1), .nz_mask(nz1));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int v, input int d);
        logic [19:0] r;
        r = '0;
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] nz_of(input int v, input int d);
        logic [4:0] m;
        int p;
        m = '0;
        p = 1;
        for (int k = 0; k < d; k++) begin
            if (k == 0 || v >= p) m[k] = 1'b1;
            p = p * 10;
        end
        return m;
    endfunction

    // Model: idle/converting/done phases with the result from decimal division.
    bit          m_ready [2] = '{1'b1, 1'b1};
    bit          m_busy  [2] = '{1'b0, 1'b0};
    bit          m_done  [2] = '{1'b0, 1'b0};
    int          m_cnt   [2] = '{0, 0};
    int          m_val   [2] = '{0, 0};
    logic [19:0] m_bcd   [2] = '{20'd0, 20'd0};
    logic [4:0]  m_nz    [2] = '{5'd1, 5'd1};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_ready[i] <= 1'b1; m_busy[i] <= 1'b0; m_done[i] <= 1'b0;
                m_cnt[i] <= 0; m_bcd[i] <= 20'd0; m_nz[i] <= 5'd1;
            end else if (m_ready[i]) begin
                if ((i == 0) ? start0 : start1) begin
                    m_ready[i] <= 1'b0;
                    m_busy[i]  <= 1'b1;
                    m_cnt[i]   <= (i == 0) ? W0 : W1;
                    m_val[i]   <= (i == 0) ? int'(bin0) : int'(bin1);
                end
            end else if (m_busy[i]) begin
                m_cnt[i] <= m_cnt[i] - 1;
                if (m_cnt[i] == 1) begin
                    m_busy[i] <= 1'b0;
                    m_done[i] <= 1'b1;
                    m_bcd[i]  <= to_bcd(m_val[i], (i == 0) ? D0 : D1);
                    m_nz[i]   <= nz_of(m_val[i], (i == 0) ? D0 : D1);
                end
            end else begin
                m_done[i]  <= 1'b0;
                m_ready[i] <= 1'b1;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("d0.ready", 32'(ready0), 32'(m_ready[0]));
            check("d0.busy",  32'(busy0),  32'(m_busy[0]));
            check("d0.done",  32'(done0),  32'(m_done[0]));
            check("d0.bcd",   32'(bcd0),   32'(m_bcd[0]));
            check("d0.nz",    32'(nz0),    32'(m_nz[0]));
            check("d1.ready", 32'(ready1), 32'(m_ready[1]));
            check("d1.busy",  32'(busy1),  32'(m_busy[1]));
            check("d1.done",  32'(done1),  32'(m_done[1]));
            check("d1.bcd",   32'(bcd1),   32'(m_bcd[1][7:0]));
            check("d1.nz",    32'(nz1),    32'(m_nz[1][1:0]));
        end
    end

    // Latency is counted in edges from the accepting edge to the edge that samples done.
    task automatic conv0(input int v, output int lat);
        @(negedge clk);
        start0 = 1'b1;
        bin0   = 16'(v);
        @(posedge clk);
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            start0 = 1'b0;
            bin0   = 16'hA5A5;
            if (done0) begin
                lat = n + 1;
                break;
            end
        end
    endtask

    task automatic conv1(input int v, output int lat);
        @(negedge clk);
        start1 = 1'b1;
        bin1   = 6'(v);
        @(posedge clk);
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            start1 = 1'b0;
            bin1   = 6'h2A;
            if (done1) begin
                lat = n + 1;
                break;
            end
        end
    endtask

    initial begin
        int lat, dcount, dpos, rbad, last;
        bit prev_done;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst.ready0", 32'(ready0), 32'd1);
        check("rst.busy0",  32'(busy0),  32'd0);
        check("rst.done0",  32'(done0),  32'd0);
        check("rst.bcd0",   32'(bcd0),   32'h0);
        check("rst.nz0",    32'(nz0),    32'b00001);
        check("rst.ready1", 32'(ready1), 32'd1);
        check("rst.nz1",    32'(nz1),    32'b01);
        rst = 1'b0;

        conv0(0, lat);
        check("zero.lat", 32'(lat), 32'd17);
        check("zero.bcd", 32'(bcd0), 32'h00000);
        check("zero.nz",  32'(nz0),  32'b00001);

        conv0(65535, lat);
        check("max.lat", 32'(lat), 32'd17);
        check("max.bcd", 32'(bcd0), 32'h65535);
        check("max.nz",  32'(nz0),  32'b11111);
        conv0(1234, lat);
        check("1234.bcd", 32'(bcd0), 32'h01234);
        check("1234.nz",  32'(nz0),  32'b01111);
        conv0(9, lat);
        check("9.bcd", 32'(bcd0), 32'h00009);
        check("9.nz",  32'(nz0),  32'b00001);

        // Second start pulse with a new value while busy must be ignored.
        @(negedge clk);
        start0 = 1'b1;
        bin0   = 16'd100;
        @(posedge clk);
        dcount = 0; dpos = -1; rbad = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (n == 0) start0 = 1'b0;
            if (n == 4) begin start0 = 1'b1; bin0 = 16'd7; end
            if (n == 5) start0 = 1'b0;
            if (n <= 16 && ready0) rbad++;
            if (n == 17) check("busy_start.ready_back", 32'(ready0), 32'd1);
            if (done0) begin dcount++; dpos = n; end
        end
        check("busy_start.done_count", 32'(dcount), 32'd1);
        check("busy_start.done_pos",   32'(dpos),   32'd16);
        check("busy_start.ready_low",  32'(rbad),   32'd0);
        check("busy_start.bcd",        32'(bcd0),   32'h00100);

        // start held high: one conversion every 18 cycles.
        @(negedge clk);
        start0 = 1'b1;
        bin0   = 16'd42;
        @(posedge clk);
        dcount = 0; last = -1; prev_done = 1'b0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (done0) begin
                if (last >= 0) check("held.spacing", 32'(n - last), 32'd18);
                else           check("held.first",   32'(n),        32'd16);
                check("held.bcd",       32'(bcd0),      32'h00042);
                check("held.no_double", 32'(prev_done), 32'd0);
                last = n;
                dcount++;
            end
            prev_done = done0;
        end
        check("held.count", 32'(dcount), 32'd4);
        start0 = 1'b0;
        dpos = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ready0) begin dpos = n; break; end
        end
        check("held.drain_timeout", 32'(dpos >= 0), 32'd1);

        // Reset in the middle of a conversion aborts it.
        @(negedge clk);
        start0 = 1'b1;
        bin0   = 16'd500;
        @(posedge clk);
        dcount = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (n == 0) start0 = 1'b0;
            if (n == 7) rst = 1'b1;
            if (n == 8) begin
                rst = 1'b0;
                check("abort.ready", 32'(ready0), 32'd1);
                check("abort.bcd",   32'(bcd0),   32'h0);
                check("abort.nz",    32'(nz0),    32'b00001);
            end
            if (done0) dcount++;
        end
        check("abort.no_done", 32'(dcount), 32'd0);
        conv0(500, lat);
        check("500.lat", 32'(lat), 32'd17);
        check("500.bcd", 32'(bcd0), 32'h00500);
        check("500.nz",  32'(nz0),  32'b00111);

        // Small instance: full sweep.
        for (int v = 0; v < 64; v++) begin
            conv1(v, lat);
            check("sweep.lat", 32'(lat), 32'd7);
            check("sweep.bcd", 32'(bcd1), 32'(((v / 10) << 4) | (v % 10)));
            check("sweep.nz",  32'(nz1),  (v >= 10) ? 32'b11 : 32'b01);
            if (v == 59) check("sweep.59", 32'(bcd1), 32'h59);
            if (v == 63) check("sweep.63", 32'(bcd1), 32'h63);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
